byte_word_packer: RTL and testbench
===================================

Name: byte_word_packer

Overview:
- Collects a byte stream from the Ethernet receive path into OUTPUT_BYTES-wide words.
- Packing is network order: the first byte received lands in the most significant byte lane. The word then feeds the byte-order swap stage and the DCT buffer.
- Valid/ready handshake on both sides.
- Handles frame-terminating partial words with a byte-keep mask.

Parameters:
- BYTE_SIZE, 8, bits per byte lane.
- OUTPUT_BYTES, 4, byte lanes per output word; legal range 2..16.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- s_data  input  BYTE_SIZE  incoming byte.
- s_valid  input  1  s_data/s_last valid.
- s_last  input  1  byte is the final byte of the frame.
- s_ready  output  1  packer accepts a byte this cycle.
- m_data  output  OUTPUT_BYTES*BYTE_SIZE  packed word; lane OUTPUT_BYTES-1 (MSB) holds the first byte.
- m_keep  output  OUTPUT_BYTES  per-lane valid mask; bit i qualifies lane i.
- m_last  output  1  word ends the frame.
- m_valid  output  1  m_data/m_keep/m_last valid.
- m_ready  input  1  downstream accepts word.

Behaviour:
- Reset: when rst_n=0 at a clock edge:
  - m_valid=0, m_data=0, m_keep=0, m_last=0.
  - Lane counter cnt=0 and accumulator cleared.
  - Any partially collected word or held output word is discarded.
  - s_ready is 0 while rst_n=0 and 1 on the first cycle after release.
- Input handshake: a byte is accepted when s_valid && s_ready.
  - s_ready = !m_valid || m_ready (combinational; no dependency on s_valid).
- Accumulation: an accepted byte is written to lane OUTPUT_BYTES-1-cnt of the accumulator.
- Word completion occurs on acceptance when cnt==OUTPUT_BYTES-1 or s_last=1. At the same edge:
  - The output register loads the accumulator including the new byte. Lanes not yet written are forced to 0.
  - m_keep = the top (cnt+1) bits set, others 0.
  - m_last = s_last.
  - m_valid <= 1.
  - cnt <= 0 and the accumulator is cleared.
- No completion: on acceptance without completion, cnt <= cnt+1 and m_valid is unchanged unless drained.
- Output hold: while m_valid && !m_ready, m_data, m_keep and m_last stay stable and s_ready=0.
- Output drain: on m_valid && m_ready with no simultaneous completion, m_valid <= 0.
- Simultaneous drain and completion in the same cycle: the new word replaces the old one and m_valid stays 1. This gives full throughput of 1 byte/cycle.
- Latency: the final byte of a word is accepted at edge N; m_valid is high from edge N onward (registered, one cycle after the byte is presented).
- Single-byte frame: s_last on the first byte gives m_keep = 1 in the MSB lane only and m_last=1.
- s_last exactly at cnt==OUTPUT_BYTES-1 gives m_keep all ones and m_last=1.
- Idle gaps (s_valid=0) mid-word: cnt and accumulator hold indefinitely.
- cnt width: $clog2(OUTPUT_BYTES). cnt never exceeds OUTPUT_BYTES-1; no wrap without completion.

Optional Feature:
- Macro: BYTE_WORD_PACKER_STATS_EN.
- When defined, two extra outputs are present:
  - frame_count (output, 16 bits): increments on each m_valid && m_ready && m_last. Wraps 0xFFFF->0x0000. Reset to 0.
  - partial_count (output, 16 bits): increments on each such handshake where m_keep is not all ones. Wraps. Reset to 0.
- When undefined, the ports and counters are absent; core behaviour is identical.

Test Plan:
- Aligned frame, OUTPUT_BYTES=4: bytes 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88 with s_last on 0x88, m_ready=1 -> words 0x11223344 keep=1111 last=0, then 0x55667788 keep=1111 last=1. s_ready stays 1 throughout.
- Partial tail: bytes 0xAA,0xBB,0xCC,0xDD,0xEE with s_last on 0xEE -> 0xAABBCCDD keep=1111 last=0, then 0xEE000000 keep=1000 last=1.
- Backpressure: m_ready=0 after the first word completes -> m_data holds 0x11223344 and s_ready=0 until m_ready=1. No byte lost or duplicated; second word follows correctly.
- Simultaneous drain/complete: continuous s_valid and m_ready=1 over 12 bytes -> 3 words on consecutive 4-cycle boundaries, m_valid never drops between them.
- Reset mid-word: accept 0x01,0x02, assert rst_n=0 for 1 cycle, then send 0x0A,0x0B,0x0C,0x0D with last -> only 0x0A0B0C0D keep=1111 is output.
- Stats (macro defined): 3 frames of 8, 5 and 1 bytes -> frame_count=3, partial_count=2. Preload 0xFFFF via 65536 single-byte frames -> wraps to 0.

Source files
------------

// File: rtl/byte_word_packer.sv
// rtl/byte_word_packer.sv - packs a byte stream into network-order words with a byte-keep mask
// Optional stats outputs (frame_count, partial_count) are enabled by defining BYTE_WORD_PACKER_STATS_EN.
module byte_word_packer #(
  parameter int BYTE_SIZE    = 8,
  parameter int OUTPUT_BYTES = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [BYTE_SIZE-1:0]              s_data,
  input  logic                              s_valid,
  input  logic                              s_last,
  output logic                              s_ready,
  output logic [OUTPUT_BYTES*BYTE_SIZE-1:0] m_data,
  output logic [OUTPUT_BYTES-1:0]           m_keep,
  output logic                              m_last,
  output logic                              m_valid,
  input  logic                              m_ready
`ifdef BYTE_WORD_PACKER_STATS_EN
  ,
  output logic [15:0]                       frame_count,
  output logic [15:0]                       partial_count
`endif
);

  localparam int W  = OUTPUT_BYTES * BYTE_SIZE;
  localparam int CW = $clog2(OUTPUT_BYTES);
  localparam logic [CW-1:0] LAST_LANE = CW'(OUTPUT_BYTES - 1);

  logic [CW-1:0]           r_cnt;
  logic [W-1:0]            r_acc;
  logic [W-1:0]            r_data;
  logic [OUTPUT_BYTES-1:0] r_keep;
  logic                    r_last;
  logic                    r_valid;

  logic [CW-1:0]           w_lane;
  logic [W-1:0]            w_acc_next;
  logic [OUTPUT_BYTES-1:0] w_keep_next;
  logic                    w_accept;
  logic                    w_complete;
  logic                    w_drain;

  assign s_ready    = rst_n && (!r_valid || m_ready);
  assign w_accept   = s_valid && s_ready;
  assign w_complete = w_accept && ((r_cnt == LAST_LANE) || s_last);
  assign w_drain    = r_valid && m_ready;

  // First byte goes to the top lane; lanes below the write point stay zero
  // because the accumulator is cleared at every completion.
  always_comb begin
    w_lane      = LAST_LANE - r_cnt;
    w_acc_next  = r_acc;
    w_keep_next = '0;
    for (int i = 0; i < OUTPUT_BYTES; i++) begin
      if (CW'(i) == w_lane) begin
        w_acc_next[i*BYTE_SIZE +: BYTE_SIZE] = s_data;
      end
      if (CW'(i) >= w_lane) begin
        w_keep_next[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_data  <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      if (w_complete) begin
        r_data  <= w_acc_next;
        r_keep  <= w_keep_next;
        r_last  <= s_last;
        r_valid <= 1'b1;
        r_cnt   <= '0;
        r_acc   <= '0;
      end else begin
        if (w_accept) begin
          r_cnt <= r_cnt + 1'b1;
          r_acc <= w_acc_next;
        end
        if (w_drain) begin
          r_valid <= 1'b0;
        end
      end
    end
  end

  assign m_data  = r_data;
  assign m_keep  = r_keep;
  assign m_last  = r_last;
  assign m_valid = r_valid;

`ifdef BYTE_WORD_PACKER_STATS_EN
  logic [15:0] r_frame_count;
  logic [15:0] r_partial_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame_count   <= '0;
      r_partial_count <= '0;
    end else if (w_drain && r_last) begin
      r_frame_count <= r_frame_count + 16'd1;
      if (r_keep != {OUTPUT_BYTES{1'b1}}) begin
        r_partial_count <= r_partial_count + 16'd1;
      end
    end
  end

  assign frame_count   = r_frame_count;
  assign partial_count = r_partial_count;
`endif

endmodule

// File: tb/tb_byte_word_packer.sv
// tb/tb_byte_word_packer.sv - randomized and directed bench for byte_word_packer against a frame-level model
module tb_byte_word_packer;

  localparam int OB = 4;
  localparam int BS = 8;

  typedef struct {
    logic [OB*BS-1:0] data;
    logic [OB-1:0]    keep;
    logic             last;
  } word_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [BS-1:0]     s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_last = 1'b0;
  logic              s_ready;
  logic [OB*BS-1:0]  m_data;
  logic [OB-1:0]     m_keep;
  logic              m_last;
  logic              m_valid;
  logic              m_ready = 1'b1;
`ifdef BYTE_WORD_PACKER_STATS_EN
  logic [15:0]       frame_count;
  logic [15:0]       partial_count;
`endif

  byte_word_packer #(.BYTE_SIZE(BS), .OUTPUT_BYTES(OB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_last  (s_last),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_keep  (m_keep),
    .m_last  (m_last),
    .m_valid (m_valid),
    .m_ready (m_ready)
`ifdef BYTE_WORD_PACKER_STATS_EN
    ,
    .frame_count   (frame_count),
    .partial_count (partial_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: bytes gathered per frame, words cut at OB bytes or s_last.
  logic [BS-1:0] cur[$];
  word_t         expq[$];
  word_t         obs[$];
  int            m_frames = 0;
  int            m_partials = 0;
  bit            comp_pending = 0;
  bit            hold_pending = 0;
  word_t         snap;

  function automatic word_t build_word(input logic last);
    word_t w;
    int n;
    n = cur.size();
    w.data = '0;
    for (int k = 0; k < n; k++) w.data |= (OB*BS)'(cur[k]) << (BS * (OB - 1 - k));
    w.keep = OB'(((1 << n) - 1) << (OB - n));
    w.last = last;
    return w;
  endfunction

  always @(negedge clk) begin
    word_t e;
    word_t o;
    if (!rst_n) begin
      cur.delete();
      expq.delete();
      comp_pending = 0;
      hold_pending = 0;
      m_frames = 0;
      m_partials = 0;
    end else begin
      if (comp_pending) check("latency_m_valid", m_valid, 1);
      comp_pending = 0;
      check("s_ready_rule", s_ready, !m_valid || m_ready);
      if (hold_pending) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, snap.data);
        check("hold_keep", m_keep, snap.keep);
        check("hold_last", m_last, snap.last);
      end
      if (m_valid && m_ready) begin
        if (expq.size() == 0) begin
          check("unexpected_word", m_data, 64'hDEAD);
        end else begin
          e = expq.pop_front();
          check("m_data", m_data, e.data);
          check("m_keep", m_keep, e.keep);
          check("m_last", m_last, e.last);
        end
        o.data = m_data; o.keep = m_keep; o.last = m_last;
        obs.push_back(o);
        if (m_last) begin
          m_frames++;
          if (m_keep != {OB{1'b1}}) m_partials++;
        end
      end
      hold_pending = m_valid && !m_ready;
      snap.data = m_data; snap.keep = m_keep; snap.last = m_last;
      if (s_valid && s_ready) begin
        cur.push_back(s_data);
        if (cur.size() == OB || s_last) begin
          expq.push_back(build_word(s_last));
          cur.delete();
          comp_pending = 1;
        end
      end
    end
  end

  // m_ready: 0 = always ready, 1 = random, 2 = rdy_force
  int rdy_mode = 0;
  logic rdy_force = 1'b1;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = rdy_force;
      endcase
    end
  end

  // All tasks start and end at posedge+1.
  task automatic send(input logic [BS-1:0] d, input logic l);
    int w;
    w = 0;
    s_data = d; s_last = l; s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) check("send_timeout", w, 0);
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((expq.size() != 0 || m_valid) && w < 500) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (w >= 500) check("drain_timeout", w, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    check("reset_s_ready", s_ready, 0);
    @(posedge clk);
    #1;
    check("reset_m_valid", m_valid, 0);
    check("reset_m_data", m_data, 0);
    check("reset_m_keep", m_keep, 0);
    check("reset_m_last", m_last, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("release_s_ready", s_ready, 1);
    @(posedge clk);
    #1;
    obs.delete();
  endtask

  task automatic check_obs(input int idx, input logic [OB*BS-1:0] d, input logic [OB-1:0] k, input logic l);
    if (obs.size() <= idx) begin
      check("obs_missing", obs.size(), idx + 1);
    end else begin
      check("dir_data", obs[idx].data, d);
      check("dir_keep", obs[idx].keep, k);
      check("dir_last", obs[idx].last, l);
    end
  endtask

  task automatic send_seq(input logic [BS-1:0] first, input int n, input logic last_at_end);
    for (int i = 0; i < n; i++) send(first + BS'(i * 8'h11), last_at_end && (i == n - 1));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    @(posedge clk);
    #1;
    do_reset();

    // Aligned frame with throughput measured in cycles
    t0 = $time;
    send_seq(8'h11, 8, 1'b1);
    check("aligned_throughput", ($time - t0) / 10, 8);
    drain();
    check("aligned_count", obs.size(), 2);
    check_obs(0, 32'h11223344, 4'b1111, 1'b0);
    check_obs(1, 32'h55667788, 4'b1111, 1'b1);

    // Partial tail
    obs.delete();
    send_seq(8'hAA, 5, 1'b1);
    drain();
    check("tail_count", obs.size(), 2);
    check_obs(0, 32'hAABBCCDD, 4'b1111, 1'b0);
    check_obs(1, 32'hEE000000, 4'b1000, 1'b1);

    // Single-byte frame
    obs.delete();
    send(8'h5A, 1'b1);
    drain();
    check_obs(0, 32'h5A000000, 4'b1000, 1'b1);

    // Backpressure after the first word
    obs.delete();
    rdy_force = 1'b0;
    rdy_mode = 2;
    fork
      send_seq(8'h11, 8, 1'b1);
      begin
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("bp_m_valid", m_valid, 1);
        check("bp_m_data", m_data, 32'h11223344);
        check("bp_s_ready", s_ready, 0);
        @(posedge clk);
        #1;
        rdy_force = 1'b1;
      end
    join
    drain();
    check("bp_count", obs.size(), 2);
    check_obs(0, 32'h11223344, 4'b1111, 1'b0);
    check_obs(1, 32'h55667788, 4'b1111, 1'b1);
    rdy_mode = 0;

    // Continuous 12 bytes: three words back to back with no stall
    obs.delete();
    t0 = $time;
    for (int i = 0; i < 12; i++) send(BS'(8'h30 + i), i == 11);
    check("stream_throughput", ($time - t0) / 10, 12);
    drain();
    check("stream_count", obs.size(), 3);
    check_obs(0, 32'h30313233, 4'b1111, 1'b0);
    check_obs(2, 32'h38393A3B, 4'b1111, 1'b1);

    // Idle gaps mid-word
    obs.delete();
    send(8'hC1, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    send(8'hC2, 1'b1);
    drain();
    check_obs(0, 32'hC1C20000, 4'b1100, 1'b1);

    // Reset mid-word
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    do_reset();
    send(8'h0A, 1'b0); send(8'h0B, 1'b0); send(8'h0C, 1'b0); send(8'h0D, 1'b1);
    drain();
    check("rst_mid_count", obs.size(), 1);
    check_obs(0, 32'h0A0B0C0D, 4'b1111, 1'b1);

    // Reset while an output word is held
    rdy_force = 1'b0;
    rdy_mode = 2;
    send_seq(8'h21, 4, 1'b0);
    do_reset();
    rdy_mode = 0;

    // Random traffic with random backpressure and gaps
    rdy_mode = 1;
    for (int i = 0; i < 400; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send(BS'($urandom), (i == 399) || ($urandom_range(0, 5) == 0));
    end
    drain();
    rdy_mode = 0;
    check("random_leftover", expq.size() + cur.size(), 0);

`ifdef BYTE_WORD_PACKER_STATS_EN
    do_reset();
    send_seq(8'h10, 8, 1'b1);
    send_seq(8'h20, 5, 1'b1);
    send(8'h30, 1'b1);
    drain();
    check("frame_count_3", frame_count, 3);
    check("partial_count_2", partial_count, 2);
    check("frame_count_model", frame_count, 16'(m_frames));
    do_reset();
    for (int i = 0; i < 65536; i++) send(BS'(i), 1'b1);
    drain();
    check("frame_count_wrap", frame_count, 0);
    check("partial_count_wrap", partial_count, 0);
    check("wrap_model", m_frames, 65536);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
